// File: rtl/ws2812_rx.sv
// WS2812 single-wire NRZ receiver: classifies each high pulse by width into a bit,
// assembles 24-bit words tagged with their LED index and reports frame ends and protocol errors.
module ws2812_rx #(
   parameter int T_BIT_THRESH = 26,
   parameter int T_MIN_HIGH   = 8,
   parameter int T_MAX_HIGH   = 60,
   parameter int RES_CYC      = 2000,
   parameter int NUM_LEDS     = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        din,
   output logic [23:0] data,
   output logic [5:0]  address,
   output logic        valid,
   output logic        frame_done,
   output logic [6:0]  led_count,
   output logic        err
);

   localparam logic [2:0] S_SYNC = 3'd0;
   localparam logic [2:0] S_IDLE = 3'd1;
   localparam logic [2:0] S_HIGH = 3'd2;
   localparam logic [2:0] S_LOW  = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd4;

   localparam logic [15:0] L_THRESH   = 16'(T_BIT_THRESH);
   localparam logic [15:0] L_MIN_HIGH = 16'(T_MIN_HIGH);
   localparam logic [15:0] L_MAX_HIGH = 16'(T_MAX_HIGH);
   localparam logic [15:0] L_RES      = 16'(RES_CYC);
   localparam logic [6:0]  L_NUM_LEDS = 7'(NUM_LEDS);

   logic        r_din_m;
   logic        r_din_s;
   logic        r_din_d;
   logic [2:0]  r_state;
   logic [15:0] r_cnt;
   logic [4:0]  r_bit;
   logic [6:0]  r_word;
   logic [22:0] r_shift;
   logic [23:0] r_data;
   logic [5:0]  r_addr;
   logic        r_valid;
   logic        r_frame_done;
   logic [6:0]  r_led_count;
   logic        r_err;

   logic        w_rise;
   logic        w_fall;
   logic [15:0] w_cnt_inc;
   logic [6:0]  w_word_inc;
   logic        w_bit_val;

   assign w_rise     = !r_din_d && r_din_s;
   assign w_fall     = r_din_d && !r_din_s;
   assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + 16'd1;
   assign w_word_inc = (&r_word) ? r_word : r_word + 7'd1;
   assign w_bit_val  = (r_cnt >= L_THRESH);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_din_m <= 1'b0;
         r_din_s <= 1'b0;
         r_din_d <= 1'b0;
      end else begin
         r_din_m <= din;
         r_din_s <= r_din_m;
         r_din_d <= r_din_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_SYNC;
         r_cnt        <= '0;
         r_bit        <= '0;
         r_word       <= '0;
         // NOTE: the shift register is reset too, so no stale bits survive an aborted frame.
         r_shift      <= '0;
         r_data       <= '0;
         r_addr       <= '0;
         r_valid      <= 1'b0;
         r_frame_done <= 1'b0;
         r_led_count  <= '0;
         r_err        <= 1'b0;
      end else begin
         r_valid      <= 1'b0;
         r_frame_done <= 1'b0;
         r_err        <= 1'b0;
         case (r_state)
            S_SYNC: begin
               if (r_din_s) begin
                  r_cnt <= '0;
               end else if (w_cnt_inc >= L_RES) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_IDLE: begin
               if (w_rise) begin
                  r_cnt   <= 16'd1;
                  r_state <= S_HIGH;
               end
            end
            S_HIGH: begin
               if (w_fall) begin
                  if (r_cnt < L_MIN_HIGH) begin
                     r_err   <= 1'b1;
                     r_state <= S_ERR;
                  end else begin
                     r_cnt   <= 16'd1;
                     r_state <= S_LOW;
                     if (r_bit == 5'd23) begin
                        // Words past the last LED are dropped; only the first one is flagged.
                        if (r_word < L_NUM_LEDS) begin
                           r_data  <= {w_bit_val, r_shift};
                           r_addr  <= r_word[5:0];
                           r_valid <= 1'b1;
                        end else if (r_word == L_NUM_LEDS) begin
                           r_err <= 1'b1;
                        end
                        r_bit  <= '0;
                        r_word <= w_word_inc;
                     end else begin
                        r_shift[r_bit] <= w_bit_val;
                        r_bit          <= r_bit + 5'd1;
                     end
                  end
               end else if (w_cnt_inc >= L_MAX_HIGH) begin
                  r_err   <= 1'b1;
                  r_state <= S_ERR;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_LOW: begin
               if (w_rise) begin
                  r_cnt   <= 16'd1;
                  r_state <= S_HIGH;
               end else if (w_cnt_inc >= L_RES) begin
                  r_err        <= (r_bit != 5'd0);
                  r_frame_done <= 1'b1;
                  r_led_count  <= r_word;
                  r_word       <= '0;
                  r_bit        <= '0;
                  r_cnt        <= '0;
                  r_state      <= S_IDLE;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_ERR: begin
               r_bit   <= '0;
               r_word  <= '0;
               r_shift <= '0;
               r_cnt   <= '0;
               r_state <= S_SYNC;
            end
            default: begin
               r_cnt   <= '0;
               r_state <= S_SYNC;
            end
         endcase
      end
   end

   assign data       = r_data;
   assign address    = r_addr;
   assign valid      = r_valid;
   assign frame_done = r_frame_done;
   assign led_count  = r_led_count;
   assign err        = r_err;

endmodule
